// File: rtl/adc_pkg.sv
// Shared types and default timing for the multiplexed analog-input converter.
package adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2
  } adc_state_t;

  localparam int NCH_DEF        = 4;
  localparam int DW_DEF         = 8;
  localparam int SAMPLE_CYC_DEF = 8;
  localparam int CONV_CYC_DEF   = 64;

  typedef logic [$clog2(NCH_DEF)-1:0] ch_idx_t;

  // Tick counter width able to hold the longer of the two phase lengths.
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/adc_conv_timer.sv
// CE-qualified phase timer: counts enabled ticks and flags the len-th one,
// restarting from zero on that tick, on clear, or while disabled.
module adc_conv_timer #(
  parameter int CW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          en,
  input  logic          clr,
  input  logic [CW-1:0] len,
  output logic          done
);

  logic [CW-1:0] cnt_r;

  assign done = en & ce & ~clr & (cnt_r == (len - CW'(1)));

  // Tick counter, zeroed on every phase entry so it can never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr || done || !en) begin
      cnt_r <= {CW{1'b0}};
    end else if (ce) begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/adc_mux_ctrl.sv
// Multiplexed ADC sequencer: channel latch, sample-hold, conversion timing, BUSY/EOC.
// Build option ADC_AUTOSCAN_EN: free-running round-robin scanner with per-channel results.
module adc_mux_ctrl
  import adc_pkg::*;
#(
  parameter int NCH        = NCH_DEF,
  parameter int DW         = DW_DEF,
  parameter int SAMPLE_CYC = SAMPLE_CYC_DEF,
  parameter int CONV_CYC   = CONV_CYC_DEF
) (
  input  logic                     MCLK,
  input  logic                     RESET,
  input  logic                     CE,
  input  logic                     START,
  input  logic [$clog2(NCH)-1:0]   CH,
  input  logic [NCH*DW-1:0]        AIN,
  output logic [DW-1:0]            DOUT,
  output logic                     BUSY,
  output logic                     EOC
);

  localparam int CHW = $clog2(NCH);
  localparam int CW  = cnt_width(SAMPLE_CYC, CONV_CYC);
  localparam logic [CW-1:0] SAMPLE_LEN = CW'(SAMPLE_CYC);
  localparam logic [CW-1:0] CONV_LEN   = CW'(CONV_CYC);

  adc_state_t      state_r, state_s;
  logic [CHW-1:0]  ch_q_r;
  logic [DW-1:0]   hold_r, dout_r, sel_s;
  logic            busy_r, eoc_r;
  logic            tmr_clr_s, tmr_en_s, tmr_done_s, capture_s, publish_s;
  logic [CW-1:0]   tmr_len_s;

  assign DOUT = dout_r;
  assign BUSY = busy_r;
  assign EOC  = eoc_r;

  assign tmr_en_s  = (state_r != ST_IDLE);
  assign tmr_len_s = (state_r == ST_CONVERT) ? CONV_LEN : SAMPLE_LEN;

  adc_conv_timer #(.CW(CW)) u_timer (
    .clk  (MCLK),
    .rst  (RESET),
    .ce   (CE),
    .en   (tmr_en_s),
    .clr  (tmr_clr_s),
    .len  (tmr_len_s),
    .done (tmr_done_s)
  );

  // Channel mux into the sample-hold; indices with no channel read as zero.
  always_comb begin
    sel_s = {DW{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      if (ch_q_r == CHW'(i)) begin
        sel_s = AIN[i*DW +: DW];
      end else begin
        sel_s = sel_s;
      end
    end
  end

`ifdef ADC_AUTOSCAN_EN

  logic [DW-1:0] result_r [NCH];
  logic [DW-1:0] rd_s;

  // Scanner sequencing: IDLE only lasts the first cycle after reset.
  always_comb begin
    state_s   = state_r;
    tmr_clr_s = 1'b0;
    capture_s = 1'b0;
    publish_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        state_s   = ST_SAMPLE;
        tmr_clr_s = 1'b1;
      end
      ST_SAMPLE: begin
        if (tmr_done_s) begin
          capture_s = 1'b1;
          state_s   = ST_CONVERT;
        end else begin
          state_s   = ST_SAMPLE;
        end
      end
      ST_CONVERT: begin
        if (tmr_done_s) begin
          publish_s = 1'b1;
          state_s   = ST_SAMPLE;
        end else begin
          state_s   = ST_CONVERT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Result readout mux for the CPU-selected channel.
  always_comb begin
    rd_s = {DW{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      if (CH == CHW'(i)) begin
        rd_s = result_r[i];
      end else begin
        rd_s = rd_s;
      end
    end
  end

  // Scanner state, per-channel results, and START-driven readout.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state_r <= ST_IDLE;
      ch_q_r  <= {CHW{1'b0}};
      hold_r  <= {DW{1'b0}};
      dout_r  <= {DW{1'b0}};
      busy_r  <= 1'b0;
      eoc_r   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        result_r[i] <= {DW{1'b0}};
      end
    end else begin
      state_r <= state_s;
      busy_r  <= 1'b0;
      if (capture_s) begin
        hold_r <= sel_s;
      end
      if (publish_s) begin
        for (int i = 0; i < NCH; i++) begin
          if (ch_q_r == CHW'(i)) begin
            result_r[i] <= hold_r;
          end
        end
        ch_q_r <= (ch_q_r == CHW'(NCH-1)) ? {CHW{1'b0}} : ch_q_r + CHW'(1);
      end
      if (START) begin
        dout_r <= rd_s;
        eoc_r  <= 1'b1;
      end
    end
  end

`else

  // Single-shot sequencing; START restarts from any state and beats completion.
  always_comb begin
    state_s   = state_r;
    tmr_clr_s = 1'b0;
    capture_s = 1'b0;
    publish_s = 1'b0;
    if (START) begin
      state_s   = ST_SAMPLE;
      tmr_clr_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: state_s = ST_IDLE;
        ST_SAMPLE: begin
          if (tmr_done_s) begin
            capture_s = 1'b1;
            state_s   = ST_CONVERT;
          end else begin
            state_s   = ST_SAMPLE;
          end
        end
        ST_CONVERT: begin
          if (tmr_done_s) begin
            publish_s = 1'b1;
            state_s   = ST_IDLE;
          end else begin
            state_s   = ST_CONVERT;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // State, channel latch, sample-hold and handshake registers.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state_r <= ST_IDLE;
      ch_q_r  <= {CHW{1'b0}};
      hold_r  <= {DW{1'b0}};
      dout_r  <= {DW{1'b0}};
      busy_r  <= 1'b0;
      eoc_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      if (capture_s) begin
        hold_r <= sel_s;
      end
      if (START) begin
        ch_q_r <= CH;
        busy_r <= 1'b1;
        eoc_r  <= 1'b0;
      end else if (publish_s) begin
        dout_r <= hold_r;
        eoc_r  <= 1'b1;
        busy_r <= 1'b0;
      end
    end
  end

`endif

endmodule
